// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one registered Gray-to-binary converter among N_REQ requesters.
// Optional adjacency checker enabled by defining GRAY_ADJ_CHK_EN.
module gray_conv_arbiter #(
  parameter int WIDTH = 4,
  parameter int N_REQ = 4,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] gray_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       bin_out,
  output logic [ID_W-1:0]        out_id,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_err
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   win;
  logic              found;
  logic              acc;
  logic [WIDTH-1:0]  cur;
  logic [WIDTH-1:0]  bin_q;
  logic [ID_W-1:0]   id_q;
  int                idx;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int k = WIDTH - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  // First requester at or above ptr, wrapping around.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = (int'(ptr_q) + off) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  // rst gates acceptance so gnt stays low throughout reset.
  assign acc = !rst && found && (state_q == StIdle || out_ready);
  assign gnt = acc ? (N_REQ'(1) << win) : '0;
  assign cur = gray_in[win*WIDTH +: WIDTH];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (acc) begin
      state_d = StHold;
      ptr_d   = (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
    end else if (state_q == StHold && out_ready) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      bin_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (acc) begin
        bin_q <= gray2bin(cur);
        id_q  <= win;
      end
    end
  end

  assign bin_out   = bin_q;
  assign out_id    = id_q;
  assign out_valid = (state_q == StHold);

`ifdef GRAY_ADJ_CHK_EN
  logic [WIDTH-1:0] last_q [N_REQ];
  logic [N_REQ-1:0] seen_q;
  logic             err_q;

  // Equal codes count as an error, as does any multi-bit jump.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        last_q[i] <= '0;
      end
    end else if (acc) begin
      err_q        <= seen_q[win] && ($countones(cur ^ last_q[win]) != 1);
      last_q[win]  <= cur;
      seen_q[win]  <= 1'b1;
    end
  end

  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
- Shares one Gray-to-binary conversion datapath among N_REQ requesters using round-robin arbitration.
- Each requester presents a WIDTH-bit Gray code with a request. The arbiter grants one requester, converts its code in a registered stage, and presents the binary result with the winner's ID on a valid/ready output port.
- Sits between Gray-coded sources (counters, encoders, pointer sync stages) and binary-consuming logic.

Parameters:
- WIDTH, 4, bit width of Gray input and binary result (>=2)
- N_REQ, 4, number of requesters (2..16)
- ID_W, $clog2(N_REQ), width of out_id (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  N_REQ  per-requester request, level; held until granted
- gray_in  input  N_REQ*WIDTH  packed Gray codes; requester i at [i*WIDTH +: WIDTH]; stable while req[i]=1
- gnt  output  N_REQ  one-hot accept pulse, combinational, one cycle per accepted request
- bin_out  output  WIDTH  converted binary value
- out_id  output  ID_W  index of requester whose result is on bin_out
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result when out_valid&&out_ready
- out_err  output  1  Gray adjacency error flag (see Optional Feature); 0 when feature disabled

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high.
- Reset values: out_valid=0, bin_out=0, out_id=0, out_err=0, rr pointer=0, state=IDLE. gnt=0 while rst=1.
- States: IDLE (no result held) and HOLD (result held, out_valid=1).
- Accept condition: acc = |req && (state==IDLE || out_ready).
- When acc is true, gnt asserts one-hot for the winner that same cycle. On the rising edge:
  - gray_in of the winner is converted and registered to bin_out.
  - out_id is set to the winner.
  - out_valid is set to 1 and state becomes HOLD.
- Conversion: bin_out[WIDTH-1] = g[WIDTH-1]; bin_out[k] = bin_out[k+1] ^ g[k] (prefix XOR from MSB).
- Latency: 1 cycle from gnt to out_valid. Throughput is 1 result per cycle while out_ready=1 and requests are pending (back-to-back, no bubble).
- HOLD with out_ready=1 and no req: go to IDLE and clear out_valid. bin_out and out_id keep their last values.
- HOLD with out_ready=0: bin_out, out_id, out_valid and out_err stay stable. gnt=0. No new acceptance.
- Round-robin:
  - The winner is the first i with req[i]=1, searching from ptr upward and wrapping N_REQ-1 to 0.
  - On acceptance, ptr becomes winner+1, wrapping to 0 after N_REQ-1.
  - ptr changes only on acceptance.
- A request dropped before grant is legal. It is simply not served.
- A requester may re-request the cycle after its gnt. It competes normally.
- Reset mid-operation discards the held result immediately: out_valid drops asynchronously and ptr returns to 0.

Optional Feature:
- Macro: GRAY_ADJ_CHK_EN.
- When defined:
  - Keeps a per-requester register of the last accepted Gray code plus a seen bit, both cleared by rst.
  - On acceptance, out_err is registered alongside bin_out. It is 1 if the seen bit is set and the new code differs from the stored code in a bit count other than exactly 1.
  - Equal codes (0 differing bits) also flag.
  - The stored code and seen bit update on every acceptance.
- When undefined: no storage is built and out_err is tied to 0.

Test Plan:
- WIDTH=4, N_REQ=4. req=0001, gray_in[3:0]=0110 -> gnt=0001 in the same cycle; next cycle out_valid=1, bin_out=0100, out_id=0.
- req=0010 with code 1000, then req=0100 with code 0000 -> bin_out=1111 (id 1), then bin_out=0000 (id 2).
- req=1111 held, out_ready=1, codes 0001/0011/0010/0110 -> gnt sequence 0001, 0010, 0100, 1000 on consecutive cycles; bin_out sequence 0001, 0010, 0011, 0100; then wraps to 0001.
- out_valid=1 with out_ready=0 for 5 cycles while req=0011 -> gnt=0, outputs frozen. Raising out_ready -> gnt issued the same cycle to the next requester after ptr.
- Assert rst mid-HOLD (no clock edge) -> out_valid=0 and gnt=0 immediately. After release, req=1010 -> first grant is 0010 (ptr=0).
- Macro defined: requester 1 sends 0001 then 0010 -> out_err=0 then 1. Then 0011 -> 0. Macro undefined: out_err always 0.
